// File: rtl/rsp_mem_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port IDs
// and the latency counter width.
package rsp_mem_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // Wide enough for the largest legal latency reload value (MEM_LAT-1 = 14).
  localparam int CNT_W = 4;

  function automatic logic [1:0] portOneHot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter that times the memory access phase: loaded when a request is
// accepted and stepped down once per access cycle until it reaches zero.
module mem_lat_counter
  import rsp_mem_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU (port 0) and the
// program loader (port 1); one transaction at a time, fixed MEM_LAT latency.
module mem_arbiter
  import rsp_mem_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [1:0]           gnt,
  output logic                 busy,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  logic [1:0]           r_state;
  logic                 r_owner;
  logic                 r_we;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_rdata;
  logic                 r_last_grant;

  logic w_start;
  logic w_pick;
  logic w_cnt_zero;
  logic w_in_access;
  logic w_in_ack;

  assign w_in_access = (r_state == S_ACCESS);
  assign w_in_ack    = (r_state == S_ACK);
  assign w_start     = (r_state == S_IDLE) && (req0 || req1);

  // On a tie the port that did not win last time gets the memory.
  always_comb begin
    w_pick = PORT_CPU;
    if (req0 && req1) begin
      w_pick = (r_last_grant == PORT_CPU) ? PORT_LDR : PORT_CPU;
    end else if (req1) begin
      w_pick = PORT_LDR;
    end
  end

  mem_lat_counter #(
    .WIDTH(CNT_W)
  ) u_lat_counter (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_start),
    .i_dec      (w_in_access && !w_cnt_zero),
    .i_load_val (CNT_W'(MEM_LAT - 1)),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= PORT_CPU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_last_grant <= PORT_LDR;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_owner <= w_pick;
            r_we    <= w_pick ? we1 : we0;
            r_addr  <= w_pick ? addr1 : addr0;
            r_wdata <= w_pick ? wdata1 : wdata0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_cnt_zero) begin
            if (!r_we) begin
              r_rdata <= mem_rdata;
            end
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_last_grant <= r_owner;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign gnt       = (w_in_access || w_in_ack) ? portOneHot(r_owner) : 2'b00;
  assign ack0      = w_in_ack && (r_owner == PORT_CPU);
  assign ack1      = w_in_ack && (r_owner == PORT_LDR);
  assign mem_en    = w_in_access;
  assign mem_we    = w_in_access && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=2 instance driven from a vector
// table plus hand sequences, and a MEM_LAT=1 instance for the short-latency case.
module tb_mem_arbiter;

  typedef struct {
    logic       r0;
    logic       w0;
    logic [7:0] a0;
    logic [7:0] d0;
    logic       r1;
    logic       w1;
    logic [7:0] a1;
    logic [7:0] d1;
    logic [1:0] eGnt;
    logic [7:0] eAddr;
    logic       eWe;
    logic [7:0] eWdata;
    logic [7:0] eRdata;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, busy, memEn, memWe;
  logic [7:0] rdata, memAddr, memWdata, memRdata;
  logic [1:0] gnt;

  logic       bReq0, bWe0, bZero;
  logic [7:0] bAddr0, bWdata0, bZeroByte;
  logic       bAck0, bAck1, bBusy, bMemEn, bMemWe;
  logic [7:0] bRdata, bMemAddr, bMemWdata, bMemRdata;
  logic [1:0] bGnt;

  logic [7:0] memArr [256];

  int totalChecks = 0;
  int badChecks   = 0;
  vec_t vecs [8];

  mem_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8), .MEM_LAT(2)) dutA (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .gnt(gnt), .busy(busy),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata)
  );

  mem_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8), .MEM_LAT(1)) dutB (
    .clk(clk), .rst(rst),
    .req0(bReq0), .req1(bZero), .we0(bWe0), .we1(bZero),
    .addr0(bAddr0), .addr1(bZeroByte), .wdata0(bWdata0), .wdata1(bZeroByte),
    .ack0(bAck0), .ack1(bAck1), .rdata(bRdata), .gnt(bGnt), .busy(bBusy),
    .mem_en(bMemEn), .mem_we(bMemWe), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
    .mem_rdata(bMemRdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple memory model: known contents after reset, writes from dutA only.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) memArr[i] <= 8'(i);
      memArr[8'h10] <= 8'hA5;
      memArr[8'h30] <= 8'h5C;
    end else if (memEn && memWe) begin
      memArr[memAddr] <= memWdata;
    end
  end

  assign memRdata  = memArr[memAddr];
  assign bMemRdata = memArr[bMemAddr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full MEM_LAT=2 transaction from idle; requester inputs are scrambled
  // once the request has been latched to show they no longer matter.
  task automatic applyStimulus(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    tick();
    checkOutput("gntAccess", gnt, v.eGnt);
    checkOutput("busyAccess", busy, 1);
    checkOutput("memEnAccess1", memEn, 1);
    checkOutput("memAddrAccess1", memAddr, v.eAddr);
    checkOutput("memWeAccess1", memWe, v.eWe);
    checkOutput("memWdataAccess1", memWdata, v.eWdata);
    req0 = 1'b0; req1 = 1'b0;
    we0 = ~v.w0; we1 = ~v.w1;
    addr0 = ~v.a0; addr1 = ~v.a1;
    wdata0 = 8'hFF; wdata1 = 8'hEE;
    tick();
    checkOutput("memEnAccess2", memEn, 1);
    checkOutput("memAddrAccess2", memAddr, v.eAddr);
    checkOutput("memWeAccess2", memWe, v.eWe);
    checkOutput("memWdataAccess2", memWdata, v.eWdata);
    checkOutput("ackEarly", {ack1, ack0}, 2'b00);
    tick();
    checkOutput("ackPort", {ack1, ack0}, v.eGnt);
    checkOutput("gntAck", gnt, v.eGnt);
    checkOutput("memEnAck", memEn, 0);
    checkOutput("rdataAck", rdata, v.eRdata);
    tick();
    checkOutput("busyIdle", busy, 0);
    checkOutput("ackIdle", {ack1, ack0}, 2'b00);
    checkOutput("gntIdle", gnt, 2'b00);
  endtask

  initial begin
    int acks;
    logic expPort;

    // r0 w0 a0 d0 | r1 w1 a1 d1 | gnt addr we wdata rdata
    vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C, 2'b10, 8'h20, 1'b1, 8'h3C, 8'h5C};
    vecs[1] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 8'h20, 1'b0, 8'h00, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 2'b10, 8'h30, 1'b0, 8'h00, 8'h5C};
    vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 2'b01, 8'h10, 1'b0, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 8'h30, 1'b0, 8'h00, 8'h5C};
    vecs[5] = '{1'b1, 1'b1, 8'h40, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 8'h40, 1'b1, 8'h77, 8'h5C};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 2'b10, 8'h40, 1'b0, 8'h00, 8'h77};
    vecs[7] = '{1'b1, 1'b1, 8'h50, 8'h11, 1'b1, 1'b1, 8'h51, 8'h22, 2'b01, 8'h50, 1'b1, 8'h11, 8'h77};

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    bReq0 = 1'b0; bWe0 = 1'b0; bAddr0 = '0; bWdata0 = '0;
    bZero = 1'b0; bZeroByte = '0;
    tick();
    tick();
    checkOutput("rstGnt", gnt, 2'b00);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstAck", {ack1, ack0}, 2'b00);
    checkOutput("rstMemEn", {memEn, memWe}, 2'b00);
    checkOutput("rstMemAddr", memAddr, 8'h00);
    checkOutput("rstMemWdata", memWdata, 8'h00);
    checkOutput("rstRdata", rdata, 8'h00);
    rst = 1'b0;
    tick();

    // Tie straight out of reset: CPU first, loader after one idle cycle.
    req0 = 1'b1; addr0 = 8'h10; req1 = 1'b1; addr1 = 8'h30;
    tick();
    checkOutput("tieGnt0", gnt, 2'b01);
    checkOutput("tieAddr0", memAddr, 8'h10);
    tick();
    checkOutput("tieNoAckYet", {ack1, ack0}, 2'b00);
    tick();
    checkOutput("tieAck0", {ack1, ack0}, 2'b01);
    checkOutput("tieRdata0", rdata, 8'hA5);
    req0 = 1'b0;
    tick();
    checkOutput("tieIdleBusy", busy, 0);
    tick();
    checkOutput("tieGnt1", gnt, 2'b10);
    checkOutput("tieAddr1", memAddr, 8'h30);
    req1 = 1'b0;
    tick();
    tick();
    checkOutput("tieAck1", {ack1, ack0}, 2'b10);
    checkOutput("tieRdata1", rdata, 8'h5C);
    tick();

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Both ports held high for six transactions after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr0 = 8'h10; addr1 = 8'h30; we0 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    acks = 0;
    expPort = 1'b0;
    for (int c = 1; c <= 40 && acks < 6; c++) begin
      tick();
      checkOutput("rrNoDoubleAck", ack0 & ack1, 0);
      checkOutput("rrGntNot11", (gnt == 2'b11), 0);
      if (ack0 || ack1) begin
        checkOutput("rrPort", ack1, expPort);
        checkOutput("rrSpacing", c, 3 + 4 * acks);
        checkOutput("rrRdata", rdata, expPort ? 8'h5C : 8'hA5);
        acks++;
        expPort = ~expPort;
        if (acks == 6) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    checkOutput("rrCount", acks, 6);
    tick();
    tick();

    // Reset in the second access cycle kills the transaction and last_grant.
    applyStimulus('{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 2'b01, 8'h10, 1'b0, 8'h00, 8'hA5});
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
    tick();
    checkOutput("abortGnt", gnt, 2'b01);
    req0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("abortMemEn", memEn, 0);
    checkOutput("abortGntRst", gnt, 2'b00);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortAck", {ack1, ack0}, 2'b00);
    checkOutput("abortRdata", rdata, 8'h00);
    rst = 1'b0;
    tick();
    checkOutput("abortNoLateAck", {ack1, ack0}, 2'b00);
    applyStimulus('{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 2'b01, 8'h10, 1'b0, 8'h00, 8'hA5});

    // MEM_LAT=1 instance: request dropped right after grant still completes.
    bReq0 = 1'b1; bWe0 = 1'b0; bAddr0 = 8'h10;
    tick();
    checkOutput("lat1Gnt", bGnt, 2'b01);
    checkOutput("lat1MemEn", bMemEn, 1);
    checkOutput("lat1MemAddr", bMemAddr, 8'h10);
    bReq0 = 1'b0;
    tick();
    checkOutput("lat1Ack", {bAck1, bAck0}, 2'b01);
    checkOutput("lat1Rdata", bRdata, 8'hA5);
    checkOutput("lat1MemEnAck", bMemEn, 0);
    tick();
    checkOutput("lat1Idle", {bBusy, bAck0, bMemWe}, 3'b000);
    checkOutput("lat1MemWdata", bMemWdata, 8'h00);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, 8, data width of memory and requester words.
REQ-002 Parameter ADDR_SIZE, 8, address width.
REQ-003 Parameter MEM_LAT, 1, cycles from access issue to valid mem_rdata; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req0, req1  input  1 each  access request; port 0 = CPU (Control_Unit side), port 1 = program loader/debug.
REQ-007 we0, we1  input  1 each  1 = write, 0 = read; sampled with req.
REQ-008 addr0, addr1  input  ADDR_SIZE each  access address.
REQ-009 wdata0, wdata1  input  WORD_SIZE each  write data.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse to the owning port.
REQ-011 rdata  output  WORD_SIZE  read data, shared by both ports, valid in the ack cycle.
REQ-012 gnt  output  2  one-hot current owner; 2'b00 when idle.
REQ-013 busy  output  1  high while a transaction is in progress.
REQ-014 mem_en, mem_we  output  1 each  memory enable and write strobe.
REQ-015 mem_addr, mem_wdata  output  ADDR_SIZE / WORD_SIZE  memory address and write data.
REQ-016 mem_rdata  input  WORD_SIZE  memory read data.

Function
REQ-017 FSM states: S_IDLE, S_ACCESS, S_ACK; no other reachable state; any illegal encoding SHALL go to S_IDLE on the next edge.
REQ-018 S_IDLE: any req high -> latch owner, we, addr, wdata; load latency counter with MEM_LAT-1; go S_ACCESS. No req -> stay.
REQ-019 Arbitration is round-robin: with req0 and req1 both high, grant the port not granted last; single request is granted regardless of history.
REQ-020 last_grant updates in S_ACK and SHALL reset to port 1, so port 0 (CPU) wins the first tie.
REQ-021 S_ACCESS: mem_en=1; mem_we=latched we; mem_addr and mem_wdata come from latched registers and stay stable for the whole state.
REQ-022 S_ACCESS: counter==0 -> capture mem_rdata into rdata if read, go S_ACK; otherwise decrement.
REQ-023 S_ACK: pulse ack of owner for exactly one cycle, mem_en=0, go S_IDLE.
REQ-024 Latency: req sampled at edge t -> ack high in cycle t+MEM_LAT+1; throughput one access per MEM_LAT+2 cycles.
REQ-025 rdata holds its last captured value between reads; writes SHALL not change rdata.
REQ-026 A req dropped after being latched does not abort the transaction; ack still pulses.
REQ-027 Requester inputs changing during S_ACCESS SHALL not affect memory outputs.
REQ-028 A requester holding req high through its ack cycle is treated as a new request, subject to round-robin.
REQ-029 gnt is one-hot of owner in S_ACCESS and S_ACK; busy = (state != S_IDLE).
REQ-030 ack0 and ack1 are never high in the same cycle; gnt is never 2'b11.

Reset
REQ-031 rst high at an edge: state=S_IDLE, gnt=0, busy=0, ack0=ack1=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, last_grant=1, counter=0.
REQ-032 rst mid-transaction aborts it: no ack issued; mem_en low from the cycle after the reset edge.

Structure
REQ-033 Shared package rsp_mem_pkg holds the state encoding (S_IDLE=0, S_ACCESS=1, S_ACK=2) and port IDs (PORT_CPU=0, PORT_LDR=1).
REQ-034 One sub-module, mem_lat_counter (load, decrement, zero flag), is natural; the rest stays in mem_arbiter.

Verification (MEM_LAT=2 unless stated)
REQ-035 req0 read addr 8'h10, mem_rdata=8'hA5 -> mem_en high 2 cycles with mem_addr=8'h10, ack0 at t+3, rdata=8'hA5.
REQ-036 req0 and req1 high together from reset -> port 0 first, then port 1; gnt sequence 01,10; acks at t+3 and t+7.
REQ-037 req1 write addr 8'h20 data 8'h3C -> mem_we=1 and mem_wdata=8'h3C for 2 cycles, ack1 pulse, rdata unchanged.
REQ-038 req0 and req1 held high continuously for 6 transactions -> strict alternation 0,1,0,1,0,1; no double ack.
REQ-039 rst asserted in 2nd S_ACCESS cycle -> no ack, mem_en=0 next cycle, gnt=0, next tie goes to port 0.
REQ-040 MEM_LAT=1, req0 dropped one cycle after grant -> ack0 still at t+2 with captured data.
